// File: rtl/wishbone_bus_if.sv
// Bridge from a combinational CPU memory port to a Wishbone B3 classic single-master bus.
// Registers each access onto the bus, stalls the core until ACK, and buffers read data over stalls.
module wishbone_bus_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_data_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o
);

  typedef enum logic [1:0] {
    StIdle         = 2'd0,
    StBusy         = 2'd1,
    StWaitForStall = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        stb_q, stb_d;
  logic        cyc_q, cyc_d;
  logic [31:0] rd_buf_q, rd_buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    cyc_d    = cyc_q;
    rd_buf_d = rd_buf_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          dat_d   = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = StBusy;
        end else begin
          addr_d = '0;
          dat_d  = '0;
          we_d   = 1'b0;
          sel_d  = '0;
          stb_d  = 1'b0;
          cyc_d  = 1'b0;
        end
      end
      StBusy: begin
        // ACK beats flush: the transfer has already happened on the bus.
        if (wishbone_ack_i) begin
          addr_d = '0;
          dat_d  = '0;
          we_d   = 1'b0;
          sel_d  = '0;
          stb_d  = 1'b0;
          cyc_d  = 1'b0;
          if (!cpu_we_i) rd_buf_d = wishbone_data_i;
          state_d = (stall_i != 6'd0) ? StWaitForStall : StIdle;
        end else if (flush_i) begin
          addr_d   = '0;
          dat_d    = '0;
          we_d     = 1'b0;
          sel_d    = '0;
          stb_d    = 1'b0;
          cyc_d    = 1'b0;
          rd_buf_d = '0;
          state_d  = StIdle;
        end
      end
      StWaitForStall: begin
        if (stall_i == 6'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = '0;
    unique case (state_q)
      StIdle: stallreq = cpu_ce_i && !flush_i;
      StBusy: begin
        if (wishbone_ack_i) begin
          cpu_data_o = cpu_we_i ? 32'd0 : wishbone_data_i;
        end else begin
          stallreq = 1'b1;
        end
      end
      StWaitForStall: cpu_data_o = rd_buf_q;
      default: ;
    endcase
  end

  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = dat_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = stb_q;
  assign wishbone_cyc_o  = cyc_q;

endmodule
